dm_responder: RTL and testbench

Memory-side responder for the CPU data-memory port. It accepts byte, half and word load/store requests over a valid/ready handshake. It stores data in a single-port, synchronous-read, word-wide RAM. Sub-word stores are done as a sequential read-modify-write, and loads return lane-extracted, sign- or zero-extended data with a registered response.

---
 rtl/dm_pkg.sv | 51 +++++
 rtl/dm_ram_1p.sv | 22 ++
 rtl/dm_responder.sv | 133 +++++++++++++
 tb/tb_dm_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings, FSM states and lane helpers for the data-memory responder
package dm_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        RSP
    } state_t;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  addr_lo,
        input logic [1:0]  len
    );
        logic [31:0] merged;
        merged = word;
        case (len)
            LEN_BYTE: merged[{addr_lo, 3'b000} +: 8]       = data[7:0];
            LEN_HALF: merged[{addr_lo[1], 4'b0000} +: 16]  = data[15:0];
            default:  merged                               = data;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  len,
        input logic        sign
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = word[{addr_lo[1], 4'b0000} +: 16];
        case (len)
            LEN_BYTE: result = {{24{lane_b[7] & sign}}, lane_b};
            LEN_HALF: result = {{16{lane_h[15] & sign}}, lane_h};
            default:  result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dm_ram_1p.sv
// rtl/dm_ram_1p.sv - single-port word RAM with registered read data
module dm_ram_1p #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - byte/half/word load-store responder with read-modify-write for sub-word stores
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_len,
    input  logic              req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic [1:0]          lat_len;
    logic                lat_sign;
    logic [31:0]         wbuf;
    logic [31:0]         ram_dout;
    logic [31:0]         ram_din;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic                accept;
    logic                req_err;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        case (req_len)
            LEN_HALF: req_err = req_addr[0];
            LEN_WORD: req_err = |req_addr[1:0];
            LEN_BYTE: req_err = 1'b0;
            default:  req_err = 1'b1;
        endcase
    end

    // Word index is truncated to the RAM depth, so out-of-range addresses wrap.
    assign ram_addr = lat_addr[IDX_W+1:2];
    assign ram_we   = (state == WR);
    assign ram_din  = (lat_len == LEN_WORD) ? lat_wdata : wbuf;

    dm_ram_1p #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RSP;
                    end else if (req_we && (req_len == LEN_WORD)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = MRG;
            MRG:     state_nxt = lat_we ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = rsp_ready ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_len   <= '0;
            lat_sign  <= 1'b0;
            wbuf      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_len   <= req_len;
                lat_sign  <= req_sign;
                rsp_err   <= req_err;
                rsp_rdata <= '0;
            end
            if (state == MRG) begin
                if (lat_we) begin
                    wbuf <= lane_merge(ram_dout, lat_wdata, lat_addr[1:0], lat_len);
                end else begin
                    rsp_rdata <= lane_extract(ram_dout, lat_addr[1:0], lat_len, lat_sign);
                end
            end
            if (state == WR) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed table plus randomized byte-model check of dm_responder
module tb_dm_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_len;
    logic        req_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests_run;
    int tests_failed;

    logic [7:0] bmem [0:16383];

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
        logic        sign;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t tbl [0:15];

    dm_responder #(.ADDR_W(14), .DEPTH(4096)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [13:0] a, input logic [31:0] wd,
                                input logic [1:0] len, input logic sg, input logic [31:0] rd,
                                input logic er, input int lat, input int hold);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.len = len; v.sign = sg;
        v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat; v.hold = hold;
        return v;
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [13:0] a, input logic [1:0] len);
        if (len == 2'b10) return 1'b1;
        return (a % nbytes(len)) != 0;
    endfunction

    function automatic int model_lat(input logic we, input logic [1:0] len, input bit er);
        if (er) return 1;
        if (!we) return 3;
        return (len == 2'b11) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [13:0] a, input logic [1:0] len, input logic sg);
        int n;
        logic [31:0] v;
        n = nbytes(len);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(bmem[(int'(a) + i) % 16384]) << (8 * i));
        end
        if (sg && n < 4 && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic model_store(input logic [13:0] a, input logic [31:0] wd, input logic [1:0] len);
        for (int i = 0; i < nbytes(len); i++) begin
            bmem[(int'(a) + i) % 16384] = 8'((wd >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_len   = v.len;
        req_sign  = v.sign;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            chk({nm, " busy req_ready"}, 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, " rdata"}, rsp_rdata, v.exp_rd);
        chk({nm, " err"}, 32'(rsp_err), 32'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            chk({nm, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, " hold rdata"}, rsp_rdata, v.exp_rd);
            chk({nm, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({nm, " rsp drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, " idle ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        bit   er;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        req_sign  = 1'b0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        tbl[0]  = mk(1'b1, 14'h100, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0,        1'b0, 2, 0);
        tbl[1]  = mk(1'b0, 14'h100, 32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 1'b0, 3, 0);
        tbl[2]  = mk(1'b1, 14'h101, 32'h000000AA, 2'b00, 1'b0, 32'h0,        1'b0, 4, 0);
        tbl[3]  = mk(1'b0, 14'h100, 32'h0,        2'b11, 1'b0, 32'hDEADAAEF, 1'b0, 3, 0);
        tbl[4]  = mk(1'b0, 14'h101, 32'h0,        2'b00, 1'b1, 32'hFFFFFFAA, 1'b0, 3, 0);
        tbl[5]  = mk(1'b0, 14'h101, 32'h0,        2'b00, 1'b0, 32'h000000AA, 1'b0, 3, 0);
        tbl[6]  = mk(1'b1, 14'h102, 32'h00001234, 2'b01, 1'b0, 32'h0,        1'b0, 4, 0);
        tbl[7]  = mk(1'b0, 14'h100, 32'h0,        2'b11, 1'b0, 32'h1234AAEF, 1'b0, 3, 0);
        tbl[8]  = mk(1'b0, 14'h100, 32'h0,        2'b01, 1'b1, 32'hFFFFAAEF, 1'b0, 3, 0);
        tbl[9]  = mk(1'b0, 14'h102, 32'h0,        2'b01, 1'b1, 32'h00001234, 1'b0, 3, 0);
        tbl[10] = mk(1'b0, 14'h102, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1, 1, 0);
        tbl[11] = mk(1'b0, 14'h101, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 1, 0);
        tbl[12] = mk(1'b0, 14'h100, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1, 0);
        tbl[13] = mk(1'b1, 14'h101, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1, 1, 0);
        tbl[14] = mk(1'b0, 14'h100, 32'h0,        2'b11, 1'b0, 32'h1234AAEF, 1'b0, 3, 0);
        tbl[15] = mk(1'b0, 14'h100, 32'h0,        2'b11, 1'b0, 32'h1234AAEF, 1'b0, 3, 5);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], $sformatf("tbl%0d", i));
            if (tbl[i].we && !tbl[i].exp_err) model_store(tbl[i].addr, tbl[i].wdata, tbl[i].len);
        end

        // store interrupted by reset while reading must leave RAM untouched
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h100;
        req_wdata = 32'h00000055;
        req_len   = 2'b00;
        req_sign  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midrd rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrd reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrd reset rsp_err", 32'(rsp_err), 32'd0);
        chk("midrd reset rsp_rdata", rsp_rdata, 32'd0);
        chk("midrd reset req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(mk(1'b0, 14'h100, 32'h0, 2'b11, 1'b0, 32'h1234AAEF, 1'b0, 3, 0), "after midrd reset");

        for (int w = 0; w < 16; w++) begin
            v = mk(1'b1, 14'(14'h200 + 4 * w), $urandom, 2'b11, 1'b0, 32'h0, 1'b0, 2, 0);
            run_op(v, $sformatf("init%0d", w));
            model_store(v.addr, v.wdata, v.len);
        end

        for (int r = 0; r < 80; r++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = 14'(14'h200 + $urandom_range(0, 63));
            v.wdata = $urandom;
            v.len   = 2'($urandom_range(0, 3));
            v.sign  = 1'($urandom_range(0, 1));
            v.hold  = int'($urandom_range(0, 2));
            er = model_err(v.addr, v.len);
            v.exp_err = er;
            v.exp_lat = model_lat(v.we, v.len, er);
            v.exp_rd  = (er || v.we) ? 32'h0 : model_load(v.addr, v.len, v.sign);
            run_op(v, $sformatf("rnd%0d", r));
            if (v.we && !er) model_store(v.addr, v.wdata, v.len);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
